// File: rtl/rect_compositor.sv
// rect_compositor: N-rectangle priority pixel compositor for the VGA game path.
// Geometry is double-buffered on frame_tick. A two-stage pixel pipeline is
// clocked by pixel_tick: hit test, then priority colour select. Overlap of
// every rectangle with rectangle 0 is accumulated per frame.
module rect_compositor #(
  parameter int N_RECT = 4,
  parameter int COORD_W = 11,
  parameter int RGB_W = 3,
  parameter logic [RGB_W-1:0] BG_COLOR = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pixel_tick,
  input  logic                      frame_tick,
  input  logic                      active,
  input  logic [9:0]                hpos,
  input  logic [9:0]                vpos,
  input  logic [N_RECT*COORD_W-1:0] rect_start_w,
  input  logic [N_RECT*COORD_W-1:0] rect_end_w,
  input  logic [N_RECT*COORD_W-1:0] rect_start_h,
  input  logic [N_RECT*COORD_W-1:0] rect_end_h,
  input  logic [N_RECT*RGB_W-1:0]   rect_color,
  input  logic [N_RECT-1:0]         rect_en,
  output logic [RGB_W-1:0]          pixel,
  output logic                      active_out,
  output logic [N_RECT-1:0]         hit_out,
  output logic [N_RECT-1:0]         coll_frame,
  output logic                      coll_valid
);

  // Active (frame-stable) copies of the rectangle description
  logic [N_RECT*COORD_W-1:0] g_sw, g_ew, g_sh, g_eh;
  logic [N_RECT*RGB_W-1:0]   g_color;
  logic [N_RECT-1:0]         g_en;

  logic [N_RECT-1:0]         hit_c;
  logic [N_RECT-1:0]         hit_s1;
  logic                      active_s1;
  logic [RGB_W-1:0]          pix_c;
  logic [N_RECT-1:0]         acc;
  logic [N_RECT-1:0]         contrib;
  logic signed [COORD_W:0]   x_ext, y_ext;

  // Latch new geometry only at frame boundaries so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_sw    <= '0;
      g_ew    <= '0;
      g_sh    <= '0;
      g_eh    <= '0;
      g_color <= '0;
      g_en    <= '0;
    end else if (frame_tick) begin
      g_sw    <= rect_start_w;
      g_ew    <= rect_end_w;
      g_sh    <= rect_start_h;
      g_eh    <= rect_end_h;
      g_color <= rect_color;
      g_en    <= rect_en;
    end
  end

  // Stage-1 hit test: unsigned screen position against signed, inclusive bounds
  always_comb begin
    x_ext = signed'({{(COORD_W-9){1'b0}}, hpos});
    y_ext = signed'({{(COORD_W-9){1'b0}}, vpos});
    hit_c = '0;
    for (int unsigned i = 0; i < N_RECT; i++) begin
      logic [COORD_W-1:0]      b_sw, b_ew, b_sh, b_eh;
      logic signed [COORD_W:0] sw, ew, sh, eh;
      b_sw = g_sw[i*COORD_W +: COORD_W];
      b_ew = g_ew[i*COORD_W +: COORD_W];
      b_sh = g_sh[i*COORD_W +: COORD_W];
      b_eh = g_eh[i*COORD_W +: COORD_W];
      sw = signed'({b_sw[COORD_W-1], b_sw});
      ew = signed'({b_ew[COORD_W-1], b_ew});
      sh = signed'({b_sh[COORD_W-1], b_sh});
      eh = signed'({b_eh[COORD_W-1], b_eh});
      hit_c[i] = g_en[i] & active & (x_ext >= sw) & (x_ext <= ew) &
                 (y_ext >= sh) & (y_ext <= eh);
    end
  end

  // Stage-1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_s1    <= '0;
      active_s1 <= 1'b0;
    end else if (pixel_tick) begin
      hit_s1    <= hit_c;
      active_s1 <= active;
    end
  end

  // Stage-2 priority select: lowest index wins, background on empty visible pixels
  always_comb begin
    logic found;
    found = 1'b0;
    pix_c = '0;
    if (active_s1) begin
      pix_c = BG_COLOR;
      for (int unsigned i = 0; i < N_RECT; i++) begin
        if (hit_s1[i] && !found) begin
          pix_c = g_color[i*RGB_W +: RGB_W];
          found = 1'b1;
        end
      end
    end
  end

  // Stage-2 output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel      <= '0;
      hit_out    <= '0;
      active_out <= 1'b0;
    end else if (pixel_tick) begin
      pixel      <= pix_c;
      hit_out    <= hit_s1;
      active_out <= active_s1;
    end
  end

  // Overlap with rect 0 for this pixel; bit 0 never reports against itself
  always_comb begin
    contrib = '0;
    for (int unsigned i = 1; i < N_RECT; i++) begin
      contrib[i] = pixel_tick & hit_s1[i] & hit_s1[0];
    end
  end

  // Per-frame collision accumulator; the frame_tick clock's own pixel is folded in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      coll_frame <= '0;
      coll_valid <= 1'b0;
    end else begin
      coll_valid <= frame_tick;
      if (frame_tick) begin
        coll_frame <= acc | contrib;
        acc        <= '0;
      end else begin
        acc <= acc | contrib;
      end
    end
  end

endmodule

// File: doc/rect_compositor.md
Name: rect_compositor

Overview:
Parametrised N-rectangle pixel compositor for the VGA game path. It replaces hard-wired ball/paddle compare chains with a generic priority compositor that supports per-rectangle colour and enable. Rectangle geometry is double-buffered at frame_tick to prevent tearing, and per-frame overlap of each rectangle with rectangle 0 (the ball) is detected on visible pixels. It sits between the object-geometry logic and the vga generator's pixel_rgb input.

Parameters:
N_RECT, 4, number of rectangles; index 0 has highest priority and is the collision reference.
COORD_W, 11, signed coordinate width of rectangle bounds.
RGB_W, 3, pixel colour width.
BG_COLOR, 0, colour output on active pixels with no hit.

Ports:
clk  in  1  system clock (50 MHz).
rst_n  in  1  asynchronous active-low reset.
pixel_tick  in  1  one-clk enable per pixel (25 MHz rate).
frame_tick  in  1  one-clk strobe on entry to vertical blanking.
active  in  1  current pixel is in the visible area.
hpos  in  10  current pixel x.
vpos  in  10  current pixel y.
rect_start_w  in  N_RECT*COORD_W  signed left bound per rect, packed with rect i at [i*COORD_W +: COORD_W].
rect_end_w  in  N_RECT*COORD_W  signed right bound, inclusive.
rect_start_h  in  N_RECT*COORD_W  signed top bound.
rect_end_h  in  N_RECT*COORD_W  signed bottom bound, inclusive.
rect_color  in  N_RECT*RGB_W  colour per rect.
rect_en  in  N_RECT  per-rect draw enable.
pixel  out  RGB_W  composited colour, 2 pixel_ticks after inputs.
active_out  out  1  active delayed to align with pixel.
hit_out  out  N_RECT  raw hit vector aligned with pixel.
coll_frame  out  N_RECT  bit i (i>=1) set if rect i overlapped rect 0 on a visible pixel last frame; bit 0 always 0.
coll_valid  out  1  one-clk pulse when coll_frame updates.

Behaviour:
- Reset (async, rst_n=0): all shadow/active geometry, colour and enable registers are 0 (nothing drawn); pixel=0, active_out=0, hit_out=0, coll_frame=0, coll_valid=0, collision accumulator=0.
- Geometry buffering: on a clk with frame_tick=1, all rect_* inputs are copied to active registers. Inputs are ignored at all other times; mid-frame changes take effect only at the next frame_tick.
- Pipeline advances only on clk with pixel_tick=1; otherwise all stages hold.
- Stage 1: for each i, hit_s1[i] = en[i] & active & (start_w<=x<=end_w) & (start_h<=y<=end_h). hpos/vpos are zero-extended to COORD_W+1 bits and compared signed against sign-extended bounds. A rect with start>end is empty. Negative or off-screen bounds are legal and are clipped naturally. active is registered alongside.
- Stage 2: pixel = colour of the lowest-index set hit_s1 bit; BG_COLOR if active_s1 and no hit; 0 if !active_s1. hit_out = hit_s1 and active_out = active_s1 are registered here. Total latency is 2 pixel_ticks, and the consumer delays syncs to match.
- Collision: on each pixel_tick, acc[i] |= hit_s1[i] & hit_s1[0] for i>=1.
- On frame_tick: coll_frame <= acc | (this clk's contribution); acc cleared to 0; coll_valid=1 for that clk. coll_valid is 0 otherwise.
- frame_tick and pixel_tick in the same clk: geometry load, pipeline advance and collision latch all occur, and stage 1 uses the pre-load geometry.
- A disabled rect never hits, never collides, and never contributes colour.
- Reset mid-frame clears everything immediately. Drawing resumes only after the first frame_tick following reset.

Test Plan:
- Reset then frame_tick with rect0=[10..14]x[20..24], colour 7, en=0001 -> pixel=7 exactly 2 pixel_ticks after hpos=10,vpos=20; pixel=BG_COLOR at hpos=15; pixel=0 while active=0.
- rect0 colour 3 and rect1 colour 5 both covering (100,100) -> pixel=3; set en[0]=0 and pulse frame_tick -> pixel=5, hit_out=0010.
- Change rect1 bounds mid-frame without frame_tick -> output unchanged that frame; new bounds drawn after next frame_tick.
- rect0 overlaps rect2 on 4 visible pixels, rect1 disjoint -> at next frame_tick coll_valid=1 for one clk, coll_frame=0100; following frame with no overlap -> coll_frame=0000.
- rect1 bounds start_w=-5, end_w=2 -> hits hpos 0..2 only; start_w=20, end_w=10 -> never hits.
- Assert rst_n low mid-line -> pixel, hit_out, coll_frame 0 asynchronously; no rect drawn until first post-reset frame_tick.
